// File: rtl/order_manager.sv
// Order manager: turns single-cycle buy/sell decisions into one outstanding
// order with position-limit risk check, fill accounting and post-fill cooldown.
module order_manager #(
  parameter int DATA_WIDTH = 16,
  parameter int POS_LIMIT  = 8,
  parameter int COOLDOWN   = 4,
  parameter int CASH_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         signal_valid,
  input  logic                         buy_signal,
  input  logic                         sell_signal,
  input  logic [DATA_WIDTH-1:0]        price_in,
  input  logic                         order_ready,
  output logic                         order_valid,
  output logic                         order_side,
  output logic [DATA_WIDTH-1:0]        order_price,
  output logic signed [7:0]            position,
  output logic signed [CASH_WIDTH-1:0] cash,
  output logic [15:0]                  reject_count,
  output logic [15:0]                  drop_count,
  output logic                         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;

  localparam logic signed [7:0] POS_MAX   = 8'(POS_LIMIT);
  localparam logic signed [7:0] POS_MIN   = -POS_MAX;
  localparam logic [7:0]        COOL_LOAD = (COOLDOWN == 0) ? 8'd0 : 8'(COOLDOWN - 1);

  logic [1:0]                   state_q, state_d;
  logic                         order_valid_q, order_valid_d;
  logic                         order_side_q, order_side_d;
  logic [DATA_WIDTH-1:0]        order_price_q, order_price_d;
  logic signed [7:0]            position_q, position_d;
  logic signed [CASH_WIDTH-1:0] cash_q, cash_d;
  logic [15:0]                  reject_q, reject_d;
  logic [15:0]                  drop_q, drop_d;
  logic [7:0]                   cool_q, cool_d;

  logic                         dec_any;
  logic                         dec_one;
  logic                         dec_both;
  logic                         risk_ok;
  logic [CASH_WIDTH-1:0]        price_ext;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign dec_any   = signal_valid & (buy_signal | sell_signal);
  assign dec_one   = signal_valid & (buy_signal ^ sell_signal);
  assign dec_both  = signal_valid & buy_signal & sell_signal;
  assign risk_ok   = (buy_signal && (position_q < POS_MAX)) ||
                     (sell_signal && (position_q > POS_MIN));
  assign price_ext = CASH_WIDTH'(order_price_q);

  always_comb begin
    state_d       = state_q;
    order_valid_d = order_valid_q;
    order_side_d  = order_side_q;
    order_price_d = order_price_q;
    position_d    = position_q;
    cash_d        = cash_q;
    reject_d      = reject_q;
    drop_d        = drop_q;
    cool_d        = cool_q;

    case (state_q)
      S_IDLE: begin
        if (dec_both) begin
          reject_d = sat_inc16(reject_q);
        end else if (dec_one) begin
          if (risk_ok) begin
            order_valid_d = 1'b1;
            order_side_d  = buy_signal;
            order_price_d = price_in;
            state_d       = S_HOLD;
          end else begin
            reject_d = sat_inc16(reject_q);
          end
        end
      end

      S_HOLD: begin
        if (dec_any) drop_d = sat_inc16(drop_q);
        // Fill: accounting lands the cycle after the handshake
        if (order_valid_q && order_ready) begin
          order_valid_d = 1'b0;
          if (order_side_q) begin
            position_d = position_q + 8'sd1;
            cash_d     = cash_q - $signed(price_ext);
          end else begin
            position_d = position_q - 8'sd1;
            cash_d     = cash_q + $signed(price_ext);
          end
          if (COOLDOWN == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_COOL;
            cool_d  = COOL_LOAD;
          end
        end
      end

      S_COOL: begin
        if (dec_any) drop_d = sat_inc16(drop_q);
        if (cool_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          cool_d = cool_q - 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      order_valid_q <= 1'b0;
      order_side_q  <= 1'b0;
      order_price_q <= '0;
      position_q    <= '0;
      cash_q        <= '0;
      reject_q      <= '0;
      drop_q        <= '0;
      cool_q        <= '0;
    end else begin
      state_q       <= state_d;
      order_valid_q <= order_valid_d;
      order_side_q  <= order_side_d;
      order_price_q <= order_price_d;
      position_q    <= position_d;
      cash_q        <= cash_d;
      reject_q      <= reject_d;
      drop_q        <= drop_d;
      cool_q        <= cool_d;
    end
  end

  assign order_valid  = order_valid_q;
  assign order_side   = order_side_q;
  assign order_price  = order_price_q;
  assign position     = position_q;
  assign cash         = cash_q;
  assign reject_count = reject_q;
  assign drop_count   = drop_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_order_manager.sv
// Bench for order_manager: default instance (COOLDOWN=4) plus a COOLDOWN=0
// instance, with an order scoreboard per instance.
module tb_order_manager;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic               sv, buy, sell, ready;
  logic [15:0]        price;
  logic               ov, side, busy;
  logic [15:0]        oprice, rej, drop;
  logic signed [7:0]  pos;
  logic signed [31:0] cash;

  logic               sv0, buy0, sell0, ready0;
  logic [15:0]        price0;
  logic               ov0, side0, busy0;
  logic [15:0]        oprice0, rej0, drop0;
  logic signed [7:0]  pos0;
  logic signed [31:0] cash0;

  order_manager dut (
    .clk(clk), .rst(rst), .signal_valid(sv), .buy_signal(buy), .sell_signal(sell),
    .price_in(price), .order_ready(ready), .order_valid(ov), .order_side(side),
    .order_price(oprice), .position(pos), .cash(cash), .reject_count(rej),
    .drop_count(drop), .busy(busy)
  );

  order_manager #(.COOLDOWN(0)) dut0 (
    .clk(clk), .rst(rst), .signal_valid(sv0), .buy_signal(buy0), .sell_signal(sell0),
    .price_in(price0), .order_ready(ready0), .order_valid(ov0), .order_side(side0),
    .order_price(oprice0), .position(pos0), .cash(cash0), .reject_count(rej0),
    .drop_count(drop0), .busy(busy0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        side;
    logic [15:0] price;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   fills_a = 0;
  int   fills_b = 0;

  task automatic push_a(input logic s, input logic [15:0] p);
    exp_t e;
    e.side = s; e.price = p;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic s, input logic [15:0] p);
    exp_t e;
    e.side = s; e.price = p;
    q_b.push_back(e);
  endtask

  // Scoreboard + hold-stability monitor, default instance
  exp_t        ea;
  logic        hold_a = 1'b0;
  logic        p_side;
  logic [15:0] p_price;
  always @(negedge clk) begin
    if (!rst && ov && ready) begin
      if (q_a.size() == 0) begin
        check("sb_a_unexpected_fill", 1, 0);
      end else begin
        ea = q_a.pop_front();
        check("sb_a_side", side, ea.side);
        check("sb_a_price", oprice, ea.price);
      end
      fills_a++;
    end
    if (ov && hold_a) begin
      check("hold_side", side, p_side);
      check("hold_price", oprice, p_price);
    end
    hold_a  = ov && !ready && !rst;
    p_side  = side;
    p_price = oprice;
  end

  exp_t eb;
  always @(negedge clk) begin
    if (!rst && ov0 && ready0) begin
      if (q_b.size() == 0) begin
        check("sb_b_unexpected_fill", 1, 0);
      end else begin
        eb = q_b.pop_front();
        check("sb_b_side", side0, eb.side);
        check("sb_b_price", oprice0, eb.price);
      end
      fills_b++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic decide(input logic b, input logic s, input logic [15:0] p);
    sv = 1'b1; buy = b; sell = s; price = p;
    tick();
    sv = 1'b0; buy = 1'b0; sell = 1'b0;
  endtask

  task automatic decide0(input logic b, input logic s, input logic [15:0] p);
    sv0 = 1'b1; buy0 = b; sell0 = s; price0 = p;
    tick();
    sv0 = 1'b0; buy0 = 1'b0; sell0 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && busy; k++) tick();
    check("idle_timeout", busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
  endtask

  int     bc;
  int     mpos, mrej;
  longint mcash;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sv = 0; buy = 0; sell = 0; price = 0; ready = 0;
    sv0 = 0; buy0 = 0; sell0 = 0; price0 = 0; ready0 = 0;
    tick(); tick();
    rst = 1'b0;

    check("rst_ov", ov, 0);
    check("rst_side", side, 0);
    check("rst_price", oprice, 0);
    check("rst_pos", pos, 0);
    check("rst_cash", cash, 0);
    check("rst_rej", rej, 0);
    check("rst_drop", drop, 0);
    check("rst_busy", busy, 0);

    // Buy 100, ready held high: one-cycle order, 5 busy cycles
    ready = 1'b1;
    push_a(1'b1, 16'd100);
    decide(1'b1, 1'b0, 16'd100);
    check("t1_ov", ov, 1);
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      tick();
      if (bc == 1) check("t1_ov_1cyc", ov, 0);
    end
    check("t1_busy_cycles", bc, 5);
    check("t1_pos", pos, 1);
    check("t1_cash", cash, -100);
    check("t1_fills", fills_a, 1);

    // Sell 250 with ready held low 5 cycles
    ready = 1'b0;
    push_a(1'b0, 16'd250);
    decide(1'b0, 1'b1, 16'd250);
    for (int i = 0; i < 5; i++) begin
      check("t2_ov_held", ov, 1);
      tick();
    end
    ready = 1'b1;
    tick();
    check("t2_ov_drop", ov, 0);
    check("t2_pos", pos, 0);
    check("t2_cash", cash, 150);
    wait_idle();
    check("t2_fills", fills_a, 2);

    // Conflict, no-side, and drop during cooldown
    decide(1'b1, 1'b1, 16'd5);
    check("t3_rej_both", rej, 1);
    check("t3_no_order", ov, 0);
    check("t3_not_busy", busy, 0);
    decide(1'b0, 1'b0, 16'd9);
    check("t3_rej_none", rej, 1);
    check("t3_none_busy", busy, 0);
    push_a(1'b1, 16'd7);
    decide(1'b1, 1'b0, 16'd7);
    tick();
    decide(1'b1, 1'b0, 16'd8);
    check("t3_drop", drop, 1);
    wait_idle();
    check("t3_pos", pos, 1);
    check("t3_cash", cash, 143);
    check("t3_fills", fills_a, 3);

    // Reset while an order is pending, with a decision in the reset cycle
    ready = 1'b0;
    push_a(1'b1, 16'd55);
    decide(1'b1, 1'b0, 16'd55);
    check("t4_ov_pending", ov, 1);
    sv = 1'b1; buy = 1'b1; price = 16'd77;
    rst = 1'b1;
    tick();
    rst = 1'b0; sv = 1'b0; buy = 1'b0;
    q_a.delete();
    check("t4_ov", ov, 0);
    check("t4_side", side, 0);
    check("t4_price", oprice, 0);
    check("t4_pos", pos, 0);
    check("t4_cash", cash, 0);
    check("t4_rej", rej, 0);
    check("t4_drop", drop, 0);
    check("t4_busy", busy, 0);
    tick();
    ready = 1'b1;
    push_a(1'b1, 16'd20);
    decide(1'b1, 1'b0, 16'd20);
    check("t4_post_ov", ov, 1);
    wait_idle();
    check("t4_post_pos", pos, 1);
    check("t4_post_cash", cash, -20);
    check("t4_fills", fills_a, 4);

    // Position limits: nine buys, then seventeen sells
    do_reset();
    ready = 1'b1;
    mpos = 0; mcash = 0; mrej = 0;
    for (int i = 0; i < 9; i++) begin
      if (mpos < 8) begin
        push_a(1'b1, 16'd10); mpos++; mcash -= 10;
      end else begin
        mrej++;
      end
      decide(1'b1, 1'b0, 16'd10);
      wait_idle();
    end
    check("t5_pos_max", pos, mpos);
    check("t5_cash", cash, mcash);
    check("t5_rej", rej, mrej);
    for (int i = 0; i < 17; i++) begin
      if (mpos > -8) begin
        push_a(1'b0, 16'd3); mpos--; mcash += 3;
      end else begin
        mrej++;
      end
      decide(1'b0, 1'b1, 16'd3);
      wait_idle();
    end
    check("t5_pos_min", pos, mpos);
    check("t5_cash2", cash, mcash);
    check("t5_rej2", rej, mrej);
    check("t5_queue_empty", q_a.size(), 0);

    // COOLDOWN=0: back-to-back orders, busy low one cycle between
    ready0 = 1'b1;
    mpos = 0; mcash = 0;
    for (int i = 0; i < 3; i++) begin
      logic s;
      s = (i % 2 == 0);
      push_b(s, 16'(30 + i));
      if (s) begin mpos++; mcash -= 30 + i; end
      else   begin mpos--; mcash += 30 + i; end
      decide0(s, !s, 16'(30 + i));
      check("t6_ov", ov0, 1);
      check("t6_busy", busy0, 1);
      tick();
      check("t6_gap_busy", busy0, 0);
      check("t6_gap_ov", ov0, 0);
    end
    check("t6_pos", pos0, mpos);
    check("t6_cash", cash0, mcash);
    check("t6_fills", fills_b, 3);
    check("t6_drop", drop0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
